// File: rtl/apb_req_arb.sv
// Round-robin arbiter that funnels NREQ requesters onto a single APB master port,
// with an optional pready timeout that completes the transfer with an error.
module apb_req_arb #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 32,
  parameter int unsigned TOCNT = 16
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic                 ack_err,
  output logic [DW-1:0]        ack_rdata,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [AW-1:0]        paddr,
  output logic [DW-1:0]        pwdata,
  output logic [DW/8-1:0]      pstrb,
  input  logic [DW-1:0]        prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  localparam int unsigned GW = $clog2(NREQ);
  localparam int unsigned CW = (TOCNT > 0) ? $clog2(TOCNT + 1) : 1;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   prio_q, prio_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   strb_q, strb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            ack_err_q, ack_err_d;
  logic [DW-1:0]   ack_rdata_q, ack_rdata_d;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [GW-1:0]   win;
  logic [GW-1:0]   cand;
  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*AW +: AW];
    assign wdata_arr[g] = req_wdata[g*DW +: DW];
  end

  // Requester index at a given offset from the current priority pointer, wrapping at NREQ.
  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return GW'(s);
  endfunction

  // A requester being acked this cycle still shows its old req level, so mask it out.
  assign elig = req & ~ack_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    ack_err_d   = 1'b0;
    ack_rdata_d = '0;
    found       = 1'b0;
    win         = '0;
    cand        = '0;

    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = rr_idx(prio_q, i);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SETUP;
          grant_d = win;
          prio_d  = rr_idx(win, 1);
          wr_d    = req_wr[win];
          addr_d  = addr_arr[win];
          wdata_d = wdata_arr[win];
          strb_d  = req_wr[win] ? '1 : '0;
          cnt_d   = '0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_d            = IDLE;
          ack_d[grant_q]     = 1'b1;
          ack_err_d          = pslverr;
          ack_rdata_d        = wr_q ? '0 : prdata;
        end else if (TOCNT != 0 && cnt_q == CW'(TOCNT - 1)) begin
          state_d            = IDLE;
          ack_d[grant_q]     = 1'b1;
          ack_err_d          = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      prio_q      <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      ack_q       <= '0;
      ack_err_q   <= 1'b0;
      ack_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      ack_q       <= ack_d;
      ack_err_q   <= ack_err_d;
      ack_rdata_q <= ack_rdata_d;
    end
  end

  assign ack       = ack_q;
  assign ack_err   = ack_err_q;
  assign ack_rdata = ack_rdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = wr_q;
  assign paddr     = addr_q;
  assign pwdata    = wdata_q;
  assign pstrb     = strb_q;

endmodule

// File: tb/tb_apb_req_arb.sv
// Directed bench for apb_req_arb: expected acks are queued at stimulus time and
// matched by a monitor as the DUT completes transfers.
module tb_apb_req_arb;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned TOCNT = 4;

  logic                 pclk;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_wr;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      ack;
  logic                 ack_err;
  logic [DW-1:0]        ack_rdata;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [AW-1:0]        paddr;
  logic [DW-1:0]        pwdata;
  logic [DW/8-1:0]      pstrb;
  logic [DW-1:0]        prdata;
  logic                 pready;
  logic                 pslverr;

  typedef struct packed {
    logic [31:0] idx;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  apb_req_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TOCNT(TOCNT)) dut (
    .pclk(pclk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .ack_err(ack_err), .ack_rdata(ack_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic push(input int unsigned idx, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.idx = idx; e.err = err; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every ack pulse must match the oldest queued expectation.
  always @(negedge pclk) begin
    if (!reset && ack !== '0) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", 64'(ack), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ack_onehot", 64'(ack), 64'(1) << e.idx);
        chk("sb_ack_err", 64'(ack_err), 64'(e.err));
        chk("sb_ack_rdata", 64'(ack_rdata), 64'(e.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [AW-1:0] exp_addr [4];
    reset = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset values
    step();
    chk("rst_psel", 64'(psel), 0);
    chk("rst_penable", 64'(penable), 0);
    chk("rst_pwrite", 64'(pwrite), 0);
    chk("rst_paddr", 64'(paddr), 0);
    chk("rst_pwdata", 64'(pwdata), 0);
    chk("rst_pstrb", 64'(pstrb), 0);
    chk("rst_ack", 64'(ack), 0);
    chk("rst_ack_err", 64'(ack_err), 0);
    chk("rst_ack_rdata", 64'(ack_rdata), 0);
    reset = 1'b0;
    step();

    // Single write, minimum latency
    req = 2'b01; req_wr = 2'b01; req_addr[11:0] = 12'h010; req_wdata[31:0] = 32'hA5A5_0001;
    pready = 1'b1;
    push(0, 1'b0, 32'h0);
    step();
    chk("wr_c1_psel", 64'(psel), 1);
    chk("wr_c1_penable", 64'(penable), 0);
    chk("wr_c1_pstrb", 64'(pstrb), 64'hF);
    chk("wr_c1_paddr", 64'(paddr), 64'h10);
    chk("wr_c1_pwrite", 64'(pwrite), 1);
    chk("wr_c1_pwdata", 64'(pwdata), 64'hA5A5_0001);
    step();
    chk("wr_c2_psel", 64'(psel), 1);
    chk("wr_c2_penable", 64'(penable), 1);
    step();
    chk("wr_c3_ack", 64'(ack), 64'b01);
    chk("wr_c3_psel", 64'(psel), 0);
    req = '0;
    step();
    chk("wr_c4_ack_cleared", 64'(ack), 0);

    // Read from requester 1 with two wait states
    req = 2'b10; req_wr = 2'b00; req_addr[23:12] = 12'h014; pready = 1'b0; prdata = 32'h1234;
    push(1, 1'b0, 32'h1234);
    step();
    chk("rd_c1_setup", 64'({psel, penable}), 64'b10);
    chk("rd_c1_pstrb", 64'(pstrb), 0);
    chk("rd_c1_pwrite", 64'(pwrite), 0);
    chk("rd_c1_paddr", 64'(paddr), 64'h14);
    step();
    chk("rd_c2_penable", 64'(penable), 1);
    chk("rd_c2_paddr", 64'(paddr), 64'h14);
    step();
    chk("rd_c3_penable", 64'(penable), 1);
    chk("rd_c3_paddr", 64'(paddr), 64'h14);
    step();
    chk("rd_c4_penable", 64'(penable), 1);
    chk("rd_c4_paddr", 64'(paddr), 64'h14);
    pready = 1'b1;
    step();
    chk("rd_c5_ack", 64'(ack), 64'b10);
    req = '0;
    step();

    // Contention: both held, expect alternating grants starting at 0
    req_wr = 2'b11; req_addr[11:0] = 12'h020; req_addr[23:12] = 12'h024; prdata = 32'h5555;
    exp_addr[0] = 12'h020; exp_addr[1] = 12'h024; exp_addr[2] = 12'h020; exp_addr[3] = 12'h024;
    for (int k = 0; k < 4; k++) push(k % 2, 1'b0, 32'h0);
    req = 2'b11;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      step();
      if (psel && !penable) begin
        chk("rr_grant_addr", 64'(paddr), 64'(exp_addr[n]));
        n++;
        if (n == 4) req = '0;
      end
    end
    chk("rr_grant_count", 64'(n), 4);
    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    step();
    chk("rr_sb_drained", 64'(sb.size()), 0);

    // Timeout after TOCNT ACCESS cycles with pready low
    req = 2'b01; req_wr = 2'b00; req_addr[11:0] = 12'h030; pready = 1'b0; prdata = 32'hDEAD;
    push(0, 1'b1, 32'h0);
    step();
    chk("to_setup", 64'({psel, penable}), 64'b10);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("to_access", 64'({psel, penable}), 64'b11);
    end
    step();
    chk("to_ack", 64'(ack), 64'b01);
    chk("to_idle", 64'({psel, penable}), 0);
    req = '0;
    step();

    // Slave error on a write
    req = 2'b10; req_wr = 2'b10; req_addr[23:12] = 12'h040; req_wdata[63:32] = 32'hCAFE;
    pready = 1'b1; pslverr = 1'b1;
    push(1, 1'b1, 32'h0);
    step();
    step();
    step();
    chk("err_ack", 64'(ack), 64'b10);
    req = '0;
    step();
    pslverr = 1'b0;

    // Reset in ACCESS abandons the transfer without ack
    req = 2'b01; req_wr = 2'b01; req_addr[11:0] = 12'h050; pready = 1'b0;
    step();
    step();
    chk("rstmid_in_access", 64'(penable), 1);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_psel_async", 64'(psel), 0);
    chk("rstmid_penable_async", 64'(penable), 0);
    req = '0;
    step();
    step();
    reset = 1'b0;
    step();
    step();
    chk("rstmid_no_ack", 64'(ack), 0);
    chk("rstmid_idle", 64'(psel), 0);

    // Priority returns to requester 0 after reset
    req = 2'b11; req_wr = 2'b00; req_addr[11:0] = 12'h060; req_addr[23:12] = 12'h064;
    pready = 1'b1; prdata = 32'h77;
    push(0, 1'b0, 32'h77);
    step();
    chk("prio_rst_grant0", 64'(paddr), 64'h60);
    req = '0;
    step();
    step();
    chk("prio_rst_ack", 64'(ack), 64'b01);
    step();
    step();
    chk("final_sb_empty", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_req_arb.md
APB_REQ_ARB -- requirements
Module: apb_req_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter AW, default 12, APB address width.
REQ-003 SHALL have parameter DW, default 32, APB data width.
REQ-004 SHALL have parameter TOCNT, default 16, pready timeout in cycles; 0 disables timeout.
REQ-005 SHALL have port pclk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port req, input, NREQ, per-requester transfer request, level, held until ack.
REQ-008 SHALL have port req_wr, input, NREQ, per-requester 1=write, 0=read.
REQ-009 SHALL have port req_addr, input, NREQ x AW, per-requester address.
REQ-010 SHALL have port req_wdata, input, NREQ x DW, per-requester write data.
REQ-011 SHALL have port ack, output, NREQ, one-cycle completion pulse to the granted requester.
REQ-012 SHALL have port ack_err, output, 1, valid with ack: 1=pslverr or timeout.
REQ-013 SHALL have port ack_rdata, output, DW, valid with ack: read data; 0 for writes and timeouts.
REQ-014 SHALL have ports psel, penable, pwrite (output, 1), paddr (output, AW), pwdata (output, DW), pstrb (output, DW/8): APB master.
REQ-015 SHALL have ports prdata (input, DW), pready (input, 1), pslverr (input, 1): APB slave response.

Function
REQ-016 SHALL implement FSM with states IDLE, SETUP, ACCESS.
REQ-017 In IDLE with any eligible req, SHALL grant one requester and go to SETUP at the next edge; otherwise stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: after reset requester 0 has highest priority; after a grant to i, priority starts at (i+1) mod NREQ.
REQ-019 A requester whose ack is high in the current cycle SHALL be ineligible that cycle (no re-grant on a stale req).
REQ-020 At grant, SHALL latch req_wr, req_addr, req_wdata of the winner; paddr/pwrite/pwdata SHALL be driven from latched values and stay stable through SETUP and ACCESS.
REQ-021 SETUP SHALL drive psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-022 ACCESS SHALL drive psel=1, penable=1 until pready=1 or timeout.
REQ-023 pstrb SHALL be all ones for writes and all zeros for reads.
REQ-024 In ACCESS with pready=1, at the next edge SHALL pulse ack[grant]=1 for one cycle, ack_err=pslverr, ack_rdata=prdata if read else 0, and go to IDLE.
REQ-025 Minimum latency: req rising in IDLE cycle 0 with pready=1 SHALL yield psel in cycle 1, penable in cycle 2, ack in cycle 3.
REQ-026 With TOCNT>0, a wait counter SHALL count consecutive ACCESS cycles with pready=0; on reaching TOCNT, the next edge SHALL pulse ack with ack_err=1, ack_rdata=0, and go to IDLE.
REQ-027 The wait counter SHALL clear on entry to SETUP and SHALL be wide enough for TOCNT without wrap.
REQ-028 Deasserting req of the granted requester mid-transfer SHALL NOT abort the APB transfer; ack is still issued.
REQ-029 Outside SETUP/ACCESS, psel and penable SHALL be 0; at most one ack bit SHALL be high in any cycle.

Reset
REQ-030 Reset SHALL asynchronously force IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, ack=0, ack_err=0, ack_rdata=0, wait counter=0, priority to requester 0.
REQ-031 Reset asserted mid-transfer SHALL abandon it without issuing ack; after release the FSM SHALL start in IDLE.

Verification
REQ-032 Single write: req[0]=1, req_addr=0x10, req_wdata=0xA5A5_0001, pready=1 -> psel cycle 1, penable cycle 2, pstrb=0xF, ack[0] cycle 3, ack_err=0.
REQ-033 Read with 2 wait states: req[1] read addr 0x14, pready low 2 ACCESS cycles, prdata=0x1234 -> ack[1] with ack_rdata=0x1234, paddr stable throughout.
REQ-034 Contention: req=2'b11 held continuously -> grant order 0,1,0,1; no requester granted twice in a row.
REQ-035 Timeout: TOCNT=4, pready held 0 -> ack after 4 ACCESS cycles with ack_err=1, ack_rdata=0; FSM back to IDLE.
REQ-036 pslverr=1 with pready=1 on write -> ack_err=1; reset asserted during ACCESS -> psel=0 immediately, no ack issued.
